// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache: geometry, address field helpers, refill states.
package cache_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned INDEX_W  = 8;
  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [2:0] {
    IDLE,
    INVAL,
    REQ,
    FILL,
    COMMIT,
    DONE
  } refill_state_t;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] index_of(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] offset_of(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/dm_cache_refill.sv
// Miss refill controller: invalidates the line, bursts 16 words from memory into it,
// commits the new tag and returns the critical word.
module dm_cache_refill
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [ADDR_W-1:0]   miss_addr,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                arr_we,
  output logic [INDEX_W-1:0]  arr_index,
  output logic [OFFSET_W-1:0] arr_offset,
  output logic [DATA_W-1:0]   arr_wdata,
  output logic                tag_we,
  output logic [INDEX_W-1:0]  tag_index,
  output logic [TAG_W-1:0]    tag_wdata,
  output logic                tag_valid_wdata,
  output logic                done_valid,
  output logic [DATA_W-1:0]   done_data,
  output logic                busy
);

  refill_state_t         state_q;
  logic [TAG_W-1:0]      tag_q;
  logic [INDEX_W-1:0]    index_q;
  logic [OFFSET_W-1:0]   offset_q;
  logic [OFFSET_W-1:0]   cnt_q;
  logic [DATA_W-1:0]     done_data_q;

  logic                  beat_c;

  assign beat_c = (state_q == FILL) && mem_rvalid;

  // Refill sequencer, address latches, beat counter and critical-word capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      index_q     <= '0;
      offset_q    <= '0;
      cnt_q       <= '0;
      done_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_valid) begin
            tag_q    <= tag_of(miss_addr);
            index_q  <= index_of(miss_addr);
            offset_q <= offset_of(miss_addr);
            state_q  <= INVAL;
          end
        end
        INVAL: state_q <= REQ;
        REQ: begin
          if (mem_req_ready) begin
            cnt_q   <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (mem_rvalid) begin
            if (cnt_q == offset_q) begin
              done_data_q <= mem_rdata;
            end
            cnt_q <= cnt_q + OFFSET_W'(1);
            if (cnt_q == '1) begin
              state_q <= COMMIT;
            end
          end
        end
        COMMIT:  state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Control strobes decode directly from the state register.
  assign miss_ready      = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign mem_req_valid   = (state_q == REQ);
  assign mem_req_addr    = {tag_q, index_q, OFFSET_W'(0)};
  assign tag_we          = (state_q == INVAL) || (state_q == COMMIT);
  assign tag_index       = index_q;
  assign tag_wdata       = tag_q;
  assign tag_valid_wdata = (state_q == COMMIT);
  assign done_valid      = (state_q == DONE);
  assign done_data       = done_data_q;

  // Beat data passes straight through to the data array in the cycle it arrives.
  assign arr_we     = beat_c;
  assign arr_index  = index_q;
  assign arr_offset = cnt_q;
  assign arr_wdata  = beat_c ? mem_rdata : '0;

endmodule

// File: tb/tb_dm_cache_refill.sv
// Scoreboard bench for dm_cache_refill: driver pushes expected events, monitor checks them.
module tb_dm_cache_refill;
  import cache_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                miss_valid;
  logic                miss_ready;
  logic [ADDR_W-1:0]   miss_addr;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;
  logic                arr_we;
  logic [INDEX_W-1:0]  arr_index;
  logic [OFFSET_W-1:0] arr_offset;
  logic [DATA_W-1:0]   arr_wdata;
  logic                tag_we;
  logic [INDEX_W-1:0]  tag_index;
  logic [TAG_W-1:0]    tag_wdata;
  logic                tag_valid_wdata;
  logic                done_valid;
  logic [DATA_W-1:0]   done_data;
  logic                busy;

  dm_cache_refill dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .arr_we(arr_we), .arr_index(arr_index), .arr_offset(arr_offset), .arr_wdata(arr_wdata),
    .tag_we(tag_we), .tag_index(tag_index), .tag_wdata(tag_wdata),
    .tag_valid_wdata(tag_valid_wdata),
    .done_valid(done_valid), .done_data(done_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned t_acc = 0;
  int unsigned n_acc = 0;
  bit          inval_seen = 1'b0;

  typedef struct packed {
    logic [INDEX_W-1:0]  idx;
    logic [OFFSET_W-1:0] off;
    logic [DATA_W-1:0]   data;
  } wr_t;
  typedef struct {
    logic [INDEX_W-1:0] idx;
    logic               valid;
    logic [TAG_W-1:0]   tag;
    int unsigned        rel;
  } tg_t;
  typedef struct {
    logic [DATA_W-1:0] data;
    int unsigned       rel;
  } dn_t;

  wr_t               wr_q[$];
  tg_t               tg_q[$];
  dn_t               dn_q[$];
  logic [ADDR_W-1:0] rq_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pop and compare whenever the DUT presents an event.
  initial forever begin
    @(negedge clk);
    if (rst !== 1'b1) begin
      if (miss_valid && miss_ready) begin
        t_acc = cyc;
        n_acc++;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (rq_q.size() == 0) chk("req_unexpected", 1, 0);
        else chk("req_addr", 64'(mem_req_addr), 64'(rq_q.pop_front()));
      end
      if (arr_we) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 64'(arr_offset), 64'hFFFF);
        else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_index", 64'(arr_index), 64'(e.idx));
          chk("wr_offset", 64'(arr_offset), 64'(e.off));
          chk("wr_data", 64'(arr_wdata), 64'(e.data));
          chk("wr_after_inval", 64'(inval_seen), 1);
        end
      end
      if (tag_we) begin
        if (tg_q.size() == 0) chk("tag_unexpected", 64'(tag_valid_wdata), 64'hFF);
        else begin
          tg_t e;
          e = tg_q.pop_front();
          chk("tag_index", 64'(tag_index), 64'(e.idx));
          chk("tag_valid", 64'(tag_valid_wdata), 64'(e.valid));
          chk("tag_cycle", 64'(cyc - t_acc), 64'(e.rel));
          if (e.valid) chk("tag_value", 64'(tag_wdata), 64'(e.tag));
        end
        inval_seen = !tag_valid_wdata;
      end
      if (done_valid) begin
        if (dn_q.size() == 0) chk("done_unexpected", 64'(done_data), 64'hFFFF_FFFF_FFFF);
        else begin
          dn_t e;
          e = dn_q.pop_front();
          chk("done_data", 64'(done_data), 64'(e.data));
          chk("done_cycle", 64'(cyc - t_acc), 64'(e.rel));
        end
      end
    end
  end

  // One complete refill; expected line base, index, tag and critical word are hand-supplied.
  task automatic do_miss(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] line,
                         input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                         input logic [DATA_W-1:0] base, input logic [DATA_W-1:0] crit,
                         input int unsigned req_wait, input bit gap,
                         input bit hold_valid, input bit stray);
    int unsigned to;
    int unsigned extra;
    tg_t t;
    dn_t d;
    extra = req_wait + (gap ? 16 : 0);
    rq_q.push_back(line);
    t.idx = idx; t.valid = 1'b0; t.tag = '0; t.rel = 1;
    tg_q.push_back(t);
    t.valid = 1'b1; t.tag = tag; t.rel = 19 + extra;
    tg_q.push_back(t);
    d.data = crit; d.rel = 20 + extra;
    dn_q.push_back(d);
    if (stray) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5555_5555;
      step();
      step();
    end
    to = 0;
    while (!miss_ready && to < 50) begin step(); to++; end
    chk("ready_timeout", 64'(to < 50), 1);
    miss_addr  = addr;
    miss_valid = 1'b1;
    step();
    if (!hold_valid) miss_valid = 1'b0;
    to = 0;
    while (!mem_req_valid && to < 20) begin step(); to++; end
    chk("req_timeout", 64'(to < 20), 1);
    mem_req_ready = 1'b0;
    for (int i = 0; i < int'(req_wait); i++) step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    for (int b = 0; b < 16; b++) begin
      wr_t w;
      if (gap) begin
        mem_rvalid = 1'b0;
        step();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = base + DATA_W'(b);
      w.idx = idx; w.off = OFFSET_W'(b); w.data = base + DATA_W'(b);
      wr_q.push_back(w);
      step();
    end
    mem_rvalid = stray;
    mem_rdata  = 32'h5555_5555;
    to = 0;
    while (!done_valid && to < 60) begin step(); to++; end
    chk("done_timeout", 64'(to < 60), 1);
    miss_valid = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    step();
  endtask

  initial begin
    int unsigned acc1;
    int unsigned to;
    tg_t t;
    rst           = 1'b1;
    miss_valid    = 1'b0;
    miss_addr     = '0;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    step();
    step();
    @(negedge clk);
    chk("rst_miss_ready", 64'(miss_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_req_valid", 64'(mem_req_valid), 0);
    chk("rst_req_addr", 64'(mem_req_addr), 0);
    chk("rst_arr_we", 64'(arr_we), 0);
    chk("rst_tag_we", 64'(tag_we), 0);
    chk("rst_tag_valid", 64'(tag_valid_wdata), 0);
    chk("rst_done_valid", 64'(done_valid), 0);
    chk("rst_done_data", 64'(done_data), 0);
    chk("rst_arr_offset", 64'(arr_offset), 0);
    step();
    rst = 1'b0;
    step();

    // basic miss, zero wait states
    do_miss(32'h1234_5678, 32'h1234_5670, 8'h67, 20'h12345, 32'hA000_0000, 32'hA000_0008,
            0, 1'b0, 1'b0, 1'b0);
    // request stall of 3 cycles and gapped beats
    do_miss(32'h0000_0A3C, 32'h0000_0A30, 8'hA3, 20'h00000, 32'hB000_0000, 32'hB000_000C,
            3, 1'b1, 1'b0, 1'b0);
    // critical word at offset 0, then offset 15 on the same line
    do_miss(32'hDEAD_BEE0, 32'hDEAD_BEE0, 8'hEE, 20'hDEADB, 32'hC000_0000, 32'hC000_0000,
            0, 1'b0, 1'b0, 1'b0);
    do_miss(32'hDEAD_BEEF, 32'hDEAD_BEE0, 8'hEE, 20'hDEADB, 32'hC100_0000, 32'hC100_000F,
            0, 1'b0, 1'b0, 1'b0);
    // miss_valid held during refill, stray rvalid in IDLE/INVAL/REQ
    do_miss(32'h8000_0105, 32'h8000_0100, 8'h10, 20'h80000, 32'hD000_0000, 32'hD000_0005,
            2, 1'b0, 1'b1, 1'b1);
    chk("ignored_accepts", 64'(n_acc), 5);
    // back-to-back, same index, different tags
    do_miss(32'h1111_1234, 32'h1111_1230, 8'h23, 20'h11111, 32'hE000_0000, 32'hE000_0004,
            0, 1'b0, 1'b0, 1'b0);
    acc1 = t_acc;
    do_miss(32'h2222_2237, 32'h2222_2230, 8'h23, 20'h22222, 32'hF000_0000, 32'hF000_0007,
            0, 1'b0, 1'b0, 1'b0);
    chk("b2b_accept_gap", 64'(t_acc - acc1), 21);

    // reset after beat 5 of a fill: back to IDLE, no commit afterwards
    rq_q.push_back(32'h3333_3340);
    t.idx = 8'h34; t.valid = 1'b0; t.tag = '0; t.rel = 1;
    tg_q.push_back(t);
    miss_addr  = 32'h3333_3345;
    miss_valid = 1'b1;
    step();
    miss_valid = 1'b0;
    to = 0;
    while (!mem_req_valid && to < 20) begin step(); to++; end
    chk("rst_test_req_timeout", 64'(to < 20), 1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int b = 0; b < 6; b++) begin
      wr_t w;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h7700_0000 + DATA_W'(b);
      w.idx = 8'h34; w.off = OFFSET_W'(b); w.data = 32'h7700_0000 + DATA_W'(b);
      wr_q.push_back(w);
      step();
    end
    mem_rvalid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    chk("midrst_miss_ready", 64'(miss_ready), 1);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_tag_we", 64'(tag_we), 0);
    chk("midrst_arr_we", 64'(arr_we), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) step();
    chk("final_wr_q_empty", 64'(wr_q.size()), 0);
    chk("final_tg_q_empty", 64'(tg_q.size()), 0);
    chk("final_dn_q_empty", 64'(dn_q.size()), 0);
    chk("final_rq_q_empty", 64'(rq_q.size()), 0);
    chk("final_accepts", 64'(n_acc), 8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
